// File: rtl/servant_mtimer_pkg.sv
// servant_mtimer_pkg: register addresses, reset values and CTRL bit positions
// for the servant machine timer, plus the Wishbone byte-lane merge helper.
package servant_mtimer_pkg;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;

  localparam logic [63:0] MTIMECMP_RST = '1;
  localparam logic [31:0] CTRL_RST     = 32'h0000_0001;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_DIV_LSB = 8;

  function automatic logic [31:0] wb_merge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servant_mtimer_if.sv
// servant_mtimer_if: 32-bit Wishbone classic bundle (cyc/stb/we/adr/dat/sel
// toward the slave, rdt/ack back); master and slave modports.
interface servant_mtimer_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [2:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we,
    output i_wb_adr, i_wb_dat, i_wb_sel,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we,
    input  i_wb_adr, i_wb_dat, i_wb_sel,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/servant_mtimer_prescaler.sv
// servant_mtimer_prescaler: counts 0..i_div while i_en, pulses o_tick when
// the count equals i_div; i_clr (CTRL write) restarts the count at 0.
module servant_mtimer_prescaler #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_div,
  output logic         o_tick
);

  logic [W-1:0] cnt;

  assign o_tick = i_en & (cnt == i_div);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) cnt <= '0;
    else if (o_tick)    cnt <= '0;
    else if (i_en)      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/servant_mtimer.sv
// servant_mtimer: 64-bit mtime/mtimecmp + CTRL on a Wishbone slave (wb),
// clk i_clk, sync reset i_rst, level irq o_timer_irq. SERVANT_MTIMER_PRESCALE_EN.
module servant_mtimer
  import servant_mtimer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  servant_mtimer_if.slave  wb,
  output logic             o_timer_irq
);

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  en;
  logic                  tick;
  logic [PRESCALE_W-1:0] div;
  logic                  access;
  logic                  wr;
  logic                  wr_ctrl;
  logic [31:0]           ctrl_rd;
  logic [31:0]           rd_mux;

  // The edge that raises ack is the one and only access edge.
  assign access  = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
  assign wr      = access & wb.i_wb_we;
  assign wr_ctrl = wr & (wb.i_wb_adr == CTRL);

  assign ctrl_rd = (32'(en) << CTRL_EN)
                 | (32'(div) << CTRL_DIV_LSB);

`ifdef SERVANT_MTIMER_PRESCALE_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div <= CTRL_RST[CTRL_DIV_LSB +: PRESCALE_W];
    end else if (wr_ctrl) begin
      for (int i = 0; i < PRESCALE_W; i++) begin
        if (wb.i_wb_sel[(CTRL_DIV_LSB + i) / 8])
          div[i] <= wb.i_wb_dat[CTRL_DIV_LSB + i];
      end
    end
  end

  servant_mtimer_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (en),
    .i_clr  (wr_ctrl),
    .i_div  (div),
    .o_tick (tick)
  );
`else
  assign div  = '0;
  assign tick = en;
`endif

  always_comb begin
    rd_mux = '0;
    case (wb.i_wb_adr)
      MTIME_LO:    rd_mux = mtime[31:0];
      MTIME_HI:    rd_mux = mtime[63:32];
      MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      CTRL:        rd_mux = ctrl_rd;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_rdt <= '0;
      mtime       <= '0;
      mtimecmp    <= MTIMECMP_RST;
      en          <= CTRL_RST[CTRL_EN];
      o_timer_irq <= 1'b0;
    end else begin
      wb.o_wb_ack <= access;
      o_timer_irq <= (mtime >= mtimecmp);
      if (access) wb.o_wb_rdt <= rd_mux;
      // A bus write to either half suppresses the tick for that cycle.
      if (wr && wb.i_wb_adr == MTIME_LO)
        mtime[31:0] <= wb_merge(mtime[31:0],
                                wb.i_wb_dat, wb.i_wb_sel);
      else if (wr && wb.i_wb_adr == MTIME_HI)
        mtime[63:32] <= wb_merge(mtime[63:32],
                                 wb.i_wb_dat, wb.i_wb_sel);
      else if (tick)
        mtime <= mtime + 64'd1;
      if (wr && wb.i_wb_adr == MTIMECMP_LO)
        mtimecmp[31:0] <= wb_merge(mtimecmp[31:0],
                                   wb.i_wb_dat, wb.i_wb_sel);
      if (wr && wb.i_wb_adr == MTIMECMP_HI)
        mtimecmp[63:32] <= wb_merge(mtimecmp[63:32],
                                    wb.i_wb_dat, wb.i_wb_sel);
      if (wr_ctrl && wb.i_wb_sel[0])
        en <= wb.i_wb_dat[CTRL_EN];
    end
  end

endmodule

// File: tb/tb_servant_mtimer.sv
// tb_servant_mtimer: scoreboard bench for servant_mtimer; reads push expected
// data, a negedge monitor pops and compares on every ack.
module tb_servant_mtimer;
  import servant_mtimer_pkg::*;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  logic irq;
  int   errors;
  int   checks;
  int   ack_cnt;
  logic prev_ack;
  exp_t q[$];
  exp_t e;

  servant_mtimer_if bus();

  servant_mtimer #(
    .PRESCALE_W (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .wb          (bus),
    .o_timer_irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_wb_ack) begin
      check("ack_gap", 64'(prev_ack), 64'd0);
      ack_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack expected none");
      end else begin
        e = q.pop_front();
        if (e.chk) check(e.name, 64'(bus.o_wb_rdt), 64'(e.exp));
      end
    end
    prev_ack = bus.o_wb_ack;
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(bit chk, logic [31:0] exp, string name);
    exp_t x;
    x.chk  = chk;
    x.exp  = exp;
    x.name = name;
    q.push_back(x);
  endtask

  // One access edge; returns #1 after it with the strobe dropped.
  task automatic wb_go(bit we, logic [2:0] adr, logic [31:0] dat,
                       logic [3:0] sel, bit chk, logic [31:0] exp,
                       string name);
    push(chk, exp, name);
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_stb = 1'b1;
    bus.i_wb_we  = we;
    bus.i_wb_adr = adr;
    bus.i_wb_dat = dat;
    bus.i_wb_sel = sel;
    @(posedge clk);
    #1;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
  endtask

  task automatic wr(logic [2:0] adr, logic [31:0] dat,
                    logic [3:0] sel);
    wb_go(1'b1, adr, dat, sel, 1'b0, 32'd0, "wr");
    idle(1);
  endtask

  task automatic rd(logic [2:0] adr, logic [31:0] exp, string name);
    wb_go(1'b0, adr, 32'd0, 4'h0, 1'b1, exp, name);
    idle(1);
  endtask

  int n0;

  initial begin
    errors   = 0;
    checks   = 0;
    ack_cnt  = 0;
    prev_ack = 1'b0;
    rst      = 1'b1;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    bus.i_wb_adr = '0;
    bus.i_wb_dat = '0;
    bus.i_wb_sel = '0;

    idle(3);
    check("rst_ack", 64'(bus.o_wb_ack), 64'd0);
    check("rst_rdt", 64'(bus.o_wb_rdt), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;

    // idle 10 cycles, read mtime
    idle(10);
    rd(MTIME_LO, 32'd10, "mtime_after_10");
    rd(MTIMECMP_LO, 32'hFFFF_FFFF, "cmp_lo_rst");
    rd(MTIMECMP_HI, 32'hFFFF_FFFF, "cmp_hi_rst");
    check("irq_idle", 64'(irq), 64'd0);

    // compare at 20
    wr(MTIME_LO, 32'd0, 4'hF);
    wr(MTIMECMP_LO, 32'd20, 4'hF);
    wr(MTIMECMP_HI, 32'd0, 4'hF);
    idle(15);
    check("irq_at_mtime20", 64'(irq), 64'd0);
    idle(1);
    check("irq_rise", 64'(irq), 64'd1);
    wb_go(1'b1, MTIMECMP_LO, 32'd100, 4'hF, 1'b0, 32'd0, "wr");
    check("irq_ack_edge", 64'(irq), 64'd1);
    idle(1);
    check("irq_drop", 64'(irq), 64'd0);

    // carry: exactly two ticks from FFFF_FFFE
    wr(CTRL, 32'd0, 4'h1);
    wr(MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    wr(MTIME_HI, 32'd0, 4'hF);
    wr(CTRL, 32'd1, 4'h1);
    wr(CTRL, 32'd0, 4'h1);
    rd(MTIME_HI, 32'd1, "carry_hi");
    rd(MTIME_LO, 32'd0, "carry_lo");

    // wrap: all ones then one tick
    wr(CTRL, 32'd1, 4'h1);
    wr(MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    wr(MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    rd(MTIME_LO, 32'd0, "wrap_lo");
    rd(MTIME_HI, 32'd0, "wrap_hi");

    // freeze and byte lanes
    wr(CTRL, 32'h0000_0300, 4'h3);
`ifdef SERVANT_MTIMER_PRESCALE_EN
    rd(CTRL, 32'h0000_0300, "ctrl_div");
`else
    rd(CTRL, 32'h0000_0000, "ctrl_div");
`endif
    wr(MTIME_LO, 32'h1234_5678, 4'hF);
    idle(50);
    rd(MTIME_LO, 32'h1234_5678, "frozen_lo");
    wr(MTIME_LO, 32'h0000_AB00, 4'h2);
    rd(MTIME_LO, 32'h1234_AB78, "byte1_lo");
    rd(MTIME_HI, 32'd0, "frozen_hi");
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    rd(3'd5, 32'd0, "adr5_rd");

    // rate over 40 cycles
    wr(MTIME_LO, 32'd0, 4'hF);
    wb_go(1'b1, CTRL, 32'h0000_0301, 4'h3, 1'b0, 32'd0, "wr");
    idle(40);
`ifdef SERVANT_MTIMER_PRESCALE_EN
    rd(MTIME_LO, 32'd10, "rate_40");
`else
    rd(MTIME_LO, 32'd40, "rate_40");
`endif

    // reset mid-transaction
    wr(MTIMECMP_HI, 32'd0, 4'hF);
    wr(MTIMECMP_LO, 32'd0, 4'hF);
    check("irq_set", 64'(irq), 64'd1);
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_stb = 1'b1;
    bus.i_wb_we  = 1'b0;
    bus.i_wb_adr = MTIME_LO;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ack", 64'(bus.o_wb_ack), 64'd0);
    check("midrst_rdt", 64'(bus.o_wb_rdt), 64'd0);
    check("midrst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    rd(MTIME_LO, 32'd0, "midrst_mtime");
    rd(MTIMECMP_LO, 32'hFFFF_FFFF, "midrst_cmp_lo");
    rd(MTIMECMP_HI, 32'hFFFF_FFFF, "midrst_cmp_hi");
    rd(CTRL, 32'd1, "midrst_ctrl");
    check("midrst_irq_low", 64'(irq), 64'd0);

    // held strobe for 6 cycles at address 6
    n0 = ack_cnt;
    push(1'b1, 32'd0, "adr6_rd");
    push(1'b1, 32'd0, "adr6_rd");
    push(1'b1, 32'd0, "adr6_rd");
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_stb = 1'b1;
    bus.i_wb_we  = 1'b0;
    bus.i_wb_adr = 3'd6;
    repeat (6) @(posedge clk);
    #1;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    idle(2);
    check("held_ack_count", 64'(ack_cnt - n0), 64'd3);

    idle(2);
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
